// File: rtl/axis_to_mt9v.sv
// AXI4-Stream (8-bit video) to MT9V-style parallel timing: data plus fm/ln.
// Line and frame timing come from parameters; the stream is pulled only on active ln slots.
module axis_to_mt9v #(
    parameter int H_ACTIVE = 752,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 94,
    parameter int P1       = 71,
    parameter int P2       = 19,
    parameter int V_BLANK  = 45000,
    parameter int CNT_W    = 16
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_video_tdata,
    input  logic       s_axis_video_tvalid,
    output logic       s_axis_video_tready,
    input  logic       s_axis_video_tuser,
    input  logic       s_axis_video_tlast,
    output logic [7:0] data,
    output logic       fm,
    output logic       ln,
    output logic       busy,
    output logic       err_underflow,
    output logic       err_eol,
    output logic       err_sof
);

    // state | meaning
    // IDLE  | discard non-SOF beats, wait for tvalid&tuser
    // LEAD  | fm high, ln low, P1 cycles before the first line
    // LINE  | one pixel slot per cycle, H_ACTIVE slots
    // HBLK  | ln low between lines, H_BLANK cycles
    // TRAIL | fm high after the last line, P2 cycles
    // VBLK  | fm low, V_BLANK cycles before the next SOF may be accepted
    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLK, TRAIL, VBLK} state_t;

    // A zero-length parameter still occupies one cycle.
    function automatic logic [CNT_W-1:0] term(input int n);
        return (n <= 1) ? '0 : CNT_W'(n - 1);
    endfunction

    localparam logic [CNT_W-1:0] LEAD_TC  = term(P1);
    localparam logic [CNT_W-1:0] PIX_TC   = term(H_ACTIVE);
    localparam logic [CNT_W-1:0] LINE_TC  = term(V_ACTIVE);
    localparam logic [CNT_W-1:0] HBLK_TC  = term(H_BLANK);
    localparam logic [CNT_W-1:0] TRAIL_TC = term(P2);
    localparam logic [CNT_W-1:0] VBLK_TC  = term(V_BLANK);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] linecnt;

    always_comb begin
        s_axis_video_tready = (state == LINE) ||
                              (state == IDLE && s_axis_video_tvalid && !s_axis_video_tuser);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            linecnt       <= '0;
            data          <= '0;
            fm            <= 1'b0;
            ln            <= 1'b0;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
            err_eol       <= 1'b0;
            err_sof       <= 1'b0;
        end else begin
            fm            <= (state == LEAD) || (state == LINE) ||
                             (state == HBLK) || (state == TRAIL);
            ln            <= (state == LINE);
            busy          <= (state != IDLE);
            data          <= '0;
            err_underflow <= 1'b0;
            err_eol       <= 1'b0;
            err_sof       <= 1'b0;

            case (state)
                IDLE: begin
                    if (s_axis_video_tvalid && s_axis_video_tuser) begin
                        state <= LEAD;
                        cnt   <= '0;
                    end
                end
                LEAD: begin
                    if (cnt == LEAD_TC) begin
                        state   <= LINE;
                        cnt     <= '0;
                        linecnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LINE: begin
                    // A missing beat still spends its slot so output timing never stalls.
                    if (s_axis_video_tvalid) begin
                        data    <= s_axis_video_tdata;
                        err_sof <= s_axis_video_tuser && !(cnt == '0 && linecnt == '0);
                        err_eol <= s_axis_video_tlast != (cnt == PIX_TC);
                    end else begin
                        err_underflow <= 1'b1;
                    end
                    if (cnt == PIX_TC) begin
                        cnt   <= '0;
                        state <= (linecnt == LINE_TC) ? TRAIL : HBLK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HBLK: begin
                    if (cnt == HBLK_TC) begin
                        state   <= LINE;
                        cnt     <= '0;
                        linecnt <= linecnt + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TRAIL: begin
                    if (cnt == TRAIL_TC) begin
                        state <= VBLK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                VBLK: begin
                    if (cnt == VBLK_TC) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_to_mt9v.sv
// Directed bench for axis_to_mt9v with small timing parameters.
// Records fm/ln/data/busy/errors per cycle and compares against hand-derived frame shapes.
module tb_axis_to_mt9v;

    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;
    localparam int H_BLANK  = 3;
    localparam int P1       = 2;
    localparam int P2       = 2;
    localparam int V_BLANK  = 5;

    // ln seen from the first fm-high cycle: 2 lead, 4 active, 3 blank, 4 active, 2 trail
    localparam logic [14:0] LN_SHAPE = 15'b001111000111100;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic [7:0] tdata;
    logic       tvalid, tready, tuser, tlast;
    logic [7:0] data;
    logic       fm, ln, busy, err_underflow, err_eol, err_sof;

    always #5 pclk = ~pclk;

    axis_to_mt9v #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .P1(P1), .P2(P2), .V_BLANK(V_BLANK), .CNT_W(16)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .s_axis_video_tdata(tdata),
        .s_axis_video_tvalid(tvalid),
        .s_axis_video_tready(tready),
        .s_axis_video_tuser(tuser),
        .s_axis_video_tlast(tlast),
        .data(data),
        .fm(fm),
        .ln(ln),
        .busy(busy),
        .err_underflow(err_underflow),
        .err_eol(err_eol),
        .err_sof(err_sof)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- source ----------------
    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        logic       v;
    } beat_t;

    beat_t beat_q[$];
    logic  fire;
    logic  cur_gap;

    task automatic push_beat(input logic [7:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l; b.v = 1'b1;
        beat_q.push_back(b);
    endtask

    task automatic push_gap();
        beat_t b;
        b.d = 8'h00; b.u = 1'b0; b.l = 1'b0; b.v = 1'b0;
        beat_q.push_back(b);
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int l = 0; l < V_ACTIVE; l++)
            for (int p = 0; p < H_ACTIVE; p++)
                push_beat(base + 8'(l * H_ACTIVE + p), (l == 0 && p == 0), (p == H_ACTIVE - 1));
    endtask

    initial begin
        tvalid  = 1'b0;
        tdata   = 8'h00;
        tuser   = 1'b0;
        tlast   = 1'b0;
        cur_gap = 1'b0;
        forever begin
            @(negedge pclk);
            fire = tvalid && tready;
            @(posedge pclk);
            #1;
            if ((fire || cur_gap) && beat_q.size() > 0) void'(beat_q.pop_front());
            cur_gap = 1'b0;
            if (beat_q.size() > 0) begin
                tvalid  = beat_q[0].v;
                tdata   = beat_q[0].v ? beat_q[0].d : 8'h00;
                tuser   = beat_q[0].u;
                tlast   = beat_q[0].l;
                cur_gap = !beat_q[0].v;
            end else begin
                tvalid = 1'b0;
                tdata  = 8'h00;
                tuser  = 1'b0;
                tlast  = 1'b0;
            end
        end
    end

    // ---------------- recorder ----------------
    logic rec = 1'b0;
    bit   tr_fm[$], tr_ln[$], tr_busy[$], tr_uf[$], tr_eol[$], tr_sof[$];
    int   tr_data[$];

    always @(negedge pclk) begin
        if (rec) begin
            tr_fm.push_back(fm);
            tr_ln.push_back(ln);
            tr_busy.push_back(busy);
            tr_uf.push_back(err_underflow);
            tr_eol.push_back(err_eol);
            tr_sof.push_back(err_sof);
            tr_data.push_back(int'(data));
        end
    end

    task automatic start_rec();
        tr_fm.delete(); tr_ln.delete(); tr_busy.delete();
        tr_uf.delete(); tr_eol.delete(); tr_sof.delete(); tr_data.delete();
        rec = 1'b1;
    endtask

    // ---------------- analysis ----------------
    int          fm_cnt, f_idx, ff_idx, rise2, busy_off, n_uf, n_eol, n_sof, uf_pix, eol_pix, sof_pix;
    logic [14:0] ln_pat;
    int          pix[$];
    int          exp_pix[$];

    task automatic analyze();
        fm_cnt = 0; f_idx = -1; ff_idx = -1; rise2 = -1; busy_off = -1;
        n_uf = 0; n_eol = 0; n_sof = 0; uf_pix = -1; eol_pix = -1; sof_pix = -1;
        ln_pat = '0;
        pix.delete();
        for (int i = 0; i < tr_fm.size(); i++) begin
            if (tr_fm[i]) fm_cnt++;
            if (f_idx < 0 && tr_fm[i]) f_idx = i;
            if (f_idx >= 0 && ff_idx < 0 && !tr_fm[i]) ff_idx = i;
            if (ff_idx >= 0 && rise2 < 0 && tr_fm[i]) rise2 = i;
            if (ff_idx >= 0 && busy_off < 0 && !tr_busy[i]) busy_off = i - ff_idx;
            if (tr_uf[i])  begin n_uf++;  uf_pix  = pix.size(); end
            if (tr_eol[i]) begin n_eol++; eol_pix = pix.size(); end
            if (tr_sof[i]) begin n_sof++; sof_pix = pix.size(); end
            if (tr_ln[i]) pix.push_back(tr_data[i]);
            if (tr_ln[i] == 1'b0 && tr_data[i] != 0) pix.push_back(-1);
        end
        if (f_idx >= 0)
            for (int i = 0; i < 15; i++)
                if (f_idx + i < tr_ln.size()) ln_pat[i] = tr_ln[f_idx + i];
    endtask

    task automatic check_pixels(input string tag);
        check_eq({tag, "_npix"}, pix.size(), exp_pix.size());
        for (int i = 0; i < exp_pix.size(); i++)
            if (i < pix.size()) check_eq($sformatf("%s_pix%0d", tag, i), pix[i], exp_pix[i]);
    endtask

    task automatic fill_exp(input int base);
        exp_pix.delete();
        for (int i = 0; i < H_ACTIVE * V_ACTIVE; i++) exp_pix.push_back(base + i);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge pclk);
        #2;
    endtask

    task automatic do_reset();
        rec   = 1'b0;
        rst_n = 1'b0;
        beat_q.delete();
        repeat (3) @(posedge pclk);
        #2 rst_n = 1'b1;
        @(posedge pclk);
        #2;
    endtask

    int tready_hi;

    initial begin
        rst_n = 1'b0;
        #12;
        // reset state
        check_eq("rst_fm", fm, 0);
        check_eq("rst_ln", ln, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", {err_underflow, err_eol, err_sof}, 0);
        check_eq("rst_tready", tready, 0);
        do_reset();

        // 1: clean continuous frame
        start_rec();
        push_frame(8'h10);
        run_cycles(40);
        analyze();
        check_eq("clean_fm_len", fm_cnt, 15);
        check_eq("clean_ln_shape", ln_pat, LN_SHAPE);
        check_eq("clean_errs", n_uf + n_eol + n_sof, 0);
        check_eq("clean_busy_off", busy_off, 5);
        fill_exp(8'h10);
        check_pixels("clean");
        check_eq("clean_q_empty", beat_q.size(), 0);

        // 2: three non-SOF beats are discarded in IDLE
        do_reset();
        start_rec();
        push_beat(8'hA1, 1'b0, 1'b0);
        push_beat(8'hA2, 1'b0, 1'b1);
        push_beat(8'hA3, 1'b0, 1'b0);
        push_frame(8'h60);
        run_cycles(40);
        analyze();
        check_eq("disc_fm_len", fm_cnt, 15);
        check_eq("disc_errs", n_uf + n_eol + n_sof, 0);
        check_eq("disc_fm_late", (f_idx >= 3) ? 1 : 0, 1);
        fill_exp(8'h60);
        check_pixels("disc");
        check_eq("disc_q_empty", beat_q.size(), 0);

        // 3: tvalid dropped on line0/pixel2
        do_reset();
        start_rec();
        push_beat(8'h20, 1'b1, 1'b0);
        push_beat(8'h21, 1'b0, 1'b0);
        push_gap();
        push_beat(8'h23, 1'b0, 1'b1);
        for (int p = 0; p < H_ACTIVE; p++) push_beat(8'(8'h24 + p), 1'b0, (p == H_ACTIVE - 1));
        run_cycles(40);
        analyze();
        check_eq("uf_fm_len", fm_cnt, 15);
        check_eq("uf_ln_shape", ln_pat, LN_SHAPE);
        check_eq("uf_count", n_uf, 1);
        check_eq("uf_pos", uf_pix, 2);
        check_eq("uf_other_errs", n_eol + n_sof, 0);
        exp_pix = '{8'h20, 8'h21, 8'h00, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        check_pixels("uf");

        // 4: early tlast on line0/pixel1, stray tuser on line1/pixel0
        do_reset();
        start_rec();
        push_beat(8'h30, 1'b1, 1'b0);
        push_beat(8'h31, 1'b0, 1'b1);
        push_beat(8'h32, 1'b0, 1'b0);
        push_beat(8'h33, 1'b0, 1'b1);
        push_beat(8'h34, 1'b1, 1'b0);
        push_beat(8'h35, 1'b0, 1'b0);
        push_beat(8'h36, 1'b0, 1'b0);
        push_beat(8'h37, 1'b0, 1'b1);
        run_cycles(40);
        analyze();
        check_eq("flag_fm_len", fm_cnt, 15);
        check_eq("flag_ln_shape", ln_pat, LN_SHAPE);
        check_eq("eol_count", n_eol, 1);
        check_eq("eol_pos", eol_pix, 1);
        check_eq("sof_count", n_sof, 1);
        check_eq("sof_pos", sof_pix, 4);
        check_eq("flag_uf", n_uf, 0);
        fill_exp(8'h30);
        check_pixels("flag");

        // 5: asynchronous reset in the middle of a line
        do_reset();
        push_frame(8'h40);
        for (int i = 0; i < 40 && !ln; i++) @(negedge pclk);
        check_eq("mid_ln_seen", ln, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_fm", fm, 0);
        check_eq("async_ln", ln, 0);
        check_eq("async_data", data, 0);
        beat_q.delete();
        repeat (3) @(posedge pclk);
        #2 rst_n = 1'b1;
        tready_hi = 0;
        repeat (4) begin
            @(negedge pclk);
            if (tready) tready_hi++;
        end
        check_eq("post_rst_tready", tready_hi, 0);
        check_eq("post_rst_busy", busy, 0);
        start_rec();
        push_frame(8'h50);
        run_cycles(40);
        analyze();
        check_eq("post_rst_fm_len", fm_cnt, 15);
        check_eq("post_rst_ln_shape", ln_pat, LN_SHAPE);
        fill_exp(8'h50);
        check_pixels("post_rst");

        // 6: two frames back to back
        do_reset();
        start_rec();
        push_frame(8'h80);
        push_frame(8'h90);
        run_cycles(70);
        analyze();
        check_eq("b2b_fm_total", fm_cnt, 30);
        check_eq("b2b_gap", (rise2 >= 0) ? rise2 - ff_idx : -1, V_BLANK + 1);
        check_eq("b2b_errs", n_uf + n_eol + n_sof, 0);
        exp_pix.delete();
        for (int i = 0; i < 8; i++) exp_pix.push_back(8'h80 + i);
        for (int i = 0; i < 8; i++) exp_pix.push_back(8'h90 + i);
        check_pixels("b2b");

        rec = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
